// File: rtl/frv_mem_responder_pkg.sv
// Shared constants for the memory responder: machine word MSB and response entry width.
// Optional macro FRV_MEM_RESPONDER_BOUNDS_CHECK_EN adds an error bit to each response entry.
// Imported by the responder top and its response FIFO.
package frv_mem_responder_pkg;

  // MSB index of a machine word.
  localparam int XL = 31;

`ifdef FRV_MEM_RESPONDER_BOUNDS_CHECK_EN
  // Response entry is {err, data}.
  localparam int FRV_MEM_RSP_W = 33;
`else
  // Response entry is data only; errors cannot occur.
  localparam int FRV_MEM_RSP_W = 32;
`endif

endpackage

// File: rtl/frv_mem_rsp_fifo.sv
// Generic synchronous FIFO holding memory responses until the requester acks them.
// Latency: a push at edge N is visible at dout in cycle N+1; pop takes effect at the edge.
// Back-pressure: push while full and pop while empty are ignored; the owner gates push with !full.
import frv_mem_responder_pkg::*;

module frv_mem_rsp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                           g_clk,
  input  logic                           g_resetn,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : store[rd_ptr];

  // Pointer and occupancy bookkeeping; reset discards every queued entry.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: dout is masked while empty.
  always_ff @(posedge g_clk) begin
    if (do_push) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/frv_mem_responder.sv
// Single-port word memory answering the req/gnt/recv/ack bus with in-order responses.
// Latency: request accepted at edge N shows recv in cycle N+1 when no older responses wait.
// Back-pressure: gnt drops while RSP_DEPTH responses are unacked. Macro: FRV_MEM_RESPONDER_BOUNDS_CHECK_EN.
import frv_mem_responder_pkg::*;

module frv_mem_responder #(
  parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter int          RSP_DEPTH = 2
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [3:0]  mem_strb,
  input  logic [XL:0] mem_wdata,
  input  logic [XL:0] mem_addr,
  output logic        mem_gnt,
  output logic        mem_recv,
  input  logic        mem_ack,
  output logic        mem_error,
  output logic [XL:0] mem_rdata
);

  localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CW = $clog2(RSP_DEPTH+1);

  logic [XL:0]              mem_array [MEM_WORDS];
  logic [XL:0]              addr_off;
  logic [IW-1:0]            idx;
  logic                     in_range;
  logic                     acc;
  logic                     pop;
  logic                     wr_en;
  logic [FRV_MEM_RSP_W-1:0] rsp_din;
  logic [FRV_MEM_RSP_W-1:0] rsp_dout;
  logic [CW-1:0]            rsp_count;
  logic                     rsp_full;
  logic                     rsp_empty;
  logic                     unused_sink;

  // Offset from the base; an address below the base wraps to a huge offset,
  // so a single unsigned compare covers both ends of the window.
  assign addr_off = mem_addr - MEM_BASE;
  assign idx      = addr_off[IW+1:2];

`ifdef FRV_MEM_RESPONDER_BOUNDS_CHECK_EN
  assign in_range = ({1'b0, addr_off} < (33'(MEM_WORDS) << 2));
`else
  assign in_range = 1'b1;
`endif

  assign mem_gnt  = (rsp_count < CW'(RSP_DEPTH));
  assign acc      = mem_req && mem_gnt;
  assign pop      = mem_recv && mem_ack;
  // Reset sampled low at the accepting edge suppresses the write.
  assign wr_en    = acc && mem_wen && in_range && g_resetn;

`ifdef FRV_MEM_RESPONDER_BOUNDS_CHECK_EN
  assign rsp_din   = {!in_range, (mem_wen || !in_range) ? 32'h0 : mem_array[idx]};
  assign mem_error = rsp_dout[32];
`else
  assign rsp_din   = mem_wen ? 32'h0 : mem_array[idx];
  assign mem_error = 1'b0;
`endif

  assign mem_rdata = rsp_dout[XL:0];
  assign mem_recv  = !rsp_empty;

  // Byte-strobed write into the array; contents survive reset.
  always_ff @(posedge g_clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_strb[b]) mem_array[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  frv_mem_rsp_fifo #(
    .WIDTH (FRV_MEM_RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .push     (acc),
    .pop      (pop),
    .din      (rsp_din),
    .dout     (rsp_dout),
    .count    (rsp_count),
    .full     (rsp_full),
    .empty    (rsp_empty)
  );

  // Address bits outside the index and the FIFO full flag are intentionally unused.
  assign unused_sink = ^{addr_off[XL:IW+2], addr_off[1:0], rsp_full};

endmodule

// File: tb/tb_frv_mem_responder.sv
module tb_frv_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 1024;
  localparam int          DEPTH = 2;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        mem_req, mem_wen, mem_ack;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata, mem_addr;
  logic        mem_gnt, mem_recv, mem_error;
  logic [31:0] mem_rdata;

  frv_mem_responder #(
    .MEM_BASE  (BASE),
    .MEM_WORDS (WORDS),
    .RSP_DEPTH (DEPTH)
  ) dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .mem_req   (mem_req),
    .mem_wen   (mem_wen),
    .mem_strb  (mem_strb),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_recv  (mem_recv),
    .mem_ack   (mem_ack),
    .mem_error (mem_error),
    .mem_rdata (mem_rdata)
  );

  always #5 g_clk = ~g_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] mm [int];

  typedef struct {
    logic        req, wen;
    logic [3:0]  strb;
    logic [31:0] wdata, addr;
    logic        ack;
    logic        gnt, recv;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_in_range(input logic [31:0] addr);
`ifdef FRV_MEM_RESPONDER_BOUNDS_CHECK_EN
    longint unsigned a = addr;
    longint unsigned lo = BASE;
    return (a >= lo) && (a < lo + 4 * WORDS);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int model_idx(input logic [31:0] addr);
    logic [31:0] off = addr - BASE;
    return int'((off >> 2) % WORDS);
  endfunction

  // Reference behaviour of one accepted request.
  task automatic model_accept(input logic wen, input logic [3:0] strb,
                              input logic [31:0] wdata, input logic [31:0] addr);
    rsp_t r;
    int   i = model_idx(addr);
    r.err  = 1'b0;
    r.data = 32'h0;
    if (!model_in_range(addr)) begin
      r.err = 1'b1;
    end else if (wen) begin
      logic [31:0] w = mm.exists(i) ? mm[i] : 32'h0;
      for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
      mm[i] = w;
    end else begin
      r.data = mm.exists(i) ? mm[i] : 32'hxxxx_xxxx;
    end
    exp_q.push_back(r);
  endtask

  // Called at posedge+1: drive, check outputs against the model, advance one edge.
  task automatic drive_cycle(input logic req, input logic wen, input logic [3:0] strb,
                             input logic [31:0] wdata, input logic [31:0] addr, input logic ack,
                             output logic o_gnt, output logic o_recv,
                             output logic [31:0] o_rdata, output logic o_err);
    logic        e_gnt, e_recv, e_err, acc, pop;
    logic [31:0] e_rdata;
    mem_req = req; mem_wen = wen; mem_strb = strb;
    mem_wdata = wdata; mem_addr = addr; mem_ack = ack;
    #1;
    e_gnt   = (exp_q.size() < DEPTH);
    e_recv  = (exp_q.size() > 0);
    e_rdata = e_recv ? exp_q[0].data : 32'h0;
    e_err   = e_recv ? exp_q[0].err : 1'b0;
    o_gnt = mem_gnt; o_recv = mem_recv; o_rdata = mem_rdata; o_err = mem_error;
    check("model_gnt", mem_gnt, e_gnt);
    check("model_recv", mem_recv, e_recv);
    check("model_rdata", mem_rdata, e_rdata);
    check("model_err", mem_error, e_err);
    acc = req && e_gnt;
    pop = e_recv && ack;
    @(posedge g_clk);
    if (pop) void'(exp_q.pop_front());
    if (acc) model_accept(wen, strb, wdata, addr);
    #1;
  endtask

  task automatic cyc(input logic req, input logic wen, input logic [3:0] strb,
                     input logic [31:0] wdata, input logic [31:0] addr, input logic ack);
    logic g, rv, e;
    logic [31:0] d;
    drive_cycle(req, wen, strb, wdata, addr, ack, g, rv, d, e);
  endtask

  function automatic vec_t mk(input logic req, input logic wen, input logic [3:0] strb,
                              input logic [31:0] wdata, input logic [31:0] addr, input logic ack,
                              input logic gnt, input logic recv, input logic [31:0] rdata);
    vec_t v;
    v.req = req; v.wen = wen; v.strb = strb; v.wdata = wdata; v.addr = addr; v.ack = ack;
    v.gnt = gnt; v.recv = recv; v.rdata = rdata; v.err = 1'b0;
    return v;
  endfunction

  initial begin
    logic        g, rv, e;
    logic [31:0] d;

    g_resetn = 1'b0;
    mem_req = 0; mem_wen = 0; mem_strb = 0; mem_wdata = 0; mem_addr = 0; mem_ack = 0;
    repeat (2) @(posedge g_clk);
    #1 g_resetn = 1'b1;
    #1;
    check("reset_gnt", mem_gnt, 1'b1);
    check("reset_recv", mem_recv, 1'b0);
    check("reset_err", mem_error, 1'b0);
    check("reset_rdata", mem_rdata, 32'h0);
    @(posedge g_clk); #1;

    // Directed table: single read, byte strobes, back-pressure.
    vecs.push_back(mk(1,1,4'hF,32'hDEAD_BEEF,32'h8000_0000,1, 1,0,32'h0));
    vecs.push_back(mk(1,0,4'h0,32'h0,        32'h8000_0000,1, 1,1,32'h0));
    vecs.push_back(mk(0,0,4'h0,32'h0,        32'h0,        1, 1,1,32'hDEAD_BEEF));
    vecs.push_back(mk(1,1,4'hF,32'h0,        32'h8000_0040,1, 1,0,32'h0));
    vecs.push_back(mk(1,1,4'h5,32'h1122_3344,32'h8000_0040,1, 1,1,32'h0));
    vecs.push_back(mk(1,0,4'h0,32'h0,        32'h8000_0040,1, 1,1,32'h0));
    vecs.push_back(mk(0,0,4'h0,32'h0,        32'h0,        1, 1,1,32'h0022_0044));
    vecs.push_back(mk(0,0,4'h0,32'h0,        32'h0,        1, 1,0,32'h0));
    vecs.push_back(mk(1,0,4'h0,32'h0,        32'h8000_0000,0, 1,0,32'h0));
    vecs.push_back(mk(1,0,4'h0,32'h0,        32'h8000_0040,0, 1,1,32'hDEAD_BEEF));
    vecs.push_back(mk(1,0,4'h0,32'h0,        32'h8000_0000,0, 0,1,32'hDEAD_BEEF));
    vecs.push_back(mk(1,0,4'h0,32'h0,        32'h8000_0000,1, 0,1,32'hDEAD_BEEF));
    vecs.push_back(mk(1,0,4'h0,32'h0,        32'h8000_0000,1, 1,1,32'h0022_0044));
    vecs.push_back(mk(0,0,4'h0,32'h0,        32'h0,        1, 1,1,32'hDEAD_BEEF));
    vecs.push_back(mk(0,0,4'h0,32'h0,        32'h0,        1, 1,0,32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive_cycle(vecs[i].req, vecs[i].wen, vecs[i].strb, vecs[i].wdata,
                  vecs[i].addr, vecs[i].ack, g, rv, d, e);
      check($sformatf("vec%0d_gnt", i), g, vecs[i].gnt);
      check($sformatf("vec%0d_recv", i), rv, vecs[i].recv);
      check($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
      check($sformatf("vec%0d_err", i), e, vecs[i].err);
    end

    // Fill words 1..15 so every word touched later has known contents.
    for (int w = 1; w < 16; w++)
      cyc(1, 1, 4'hF, 32'h0101_0101 * w, BASE + 32'(4 * w), 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Streaming reads with ack held high: gnt every cycle, depth never beyond 1.
    for (int w = 0; w < 8; w++) begin
      drive_cycle(1, 0, 0, 0, BASE + 32'(4 * w), 1, g, rv, d, e);
      check("stream_gnt", g, 1'b1);
      check("stream_depth_le1", 32'(exp_q.size() <= 1), 32'h1);
    end
    cyc(0, 0, 0, 0, 0, 1);

    // Address outside the window.
    drive_cycle(1, 0, 0, 0, 32'h8000_1000, 1, g, rv, d, e);
    drive_cycle(0, 0, 0, 0, 0, 1, g, rv, d, e);
    check("oob_read_recv", rv, 1'b1);
`ifdef FRV_MEM_RESPONDER_BOUNDS_CHECK_EN
    check("oob_read_err", e, 1'b1);
    check("oob_read_rdata", d, 32'h0);
    drive_cycle(1, 1, 4'hF, 32'h5555_5555, 32'h7FFF_FFFC, 1, g, rv, d, e);
    drive_cycle(0, 0, 0, 0, 0, 1, g, rv, d, e);
    check("oob_write_err", e, 1'b1);
`else
    check("alias_read_err", e, 1'b0);
    check("alias_read_rdata", d, 32'hDEAD_BEEF);
`endif
    drive_cycle(1, 0, 0, 0, BASE, 1, g, rv, d, e);
    drive_cycle(0, 0, 0, 0, 0, 1, g, rv, d, e);
    check("word0_intact", d, 32'hDEAD_BEEF);
    cyc(0, 0, 0, 0, 0, 1);

    // Randomised traffic over words 0..15 plus aliased/out-of-window addresses.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = (($urandom_range(0, 7) == 0) ? 32'h8000_1000 : BASE)
          + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom),
          $urandom, a, $urandom_range(0, 2) != 0);
    end
    for (int n = 0; n < 4; n++) cyc(0, 0, 0, 0, 0, 1);

    // Reset with two responses queued.
    cyc(1, 0, 0, 0, BASE + 32'h40, 0);
    cyc(1, 0, 0, 0, BASE, 0);
    check("pre_reset_depth", 32'(exp_q.size()), 32'd2);
    check("pre_reset_gnt", mem_gnt, 1'b0);
    mem_req = 0; mem_ack = 0;
    g_resetn = 1'b0;
    #1;
    check("in_reset_recv", mem_recv, 1'b0);
    check("in_reset_gnt", mem_gnt, 1'b1);
    exp_q.delete();
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
    check("post_reset_gnt", mem_gnt, 1'b1);
    check("post_reset_recv", mem_recv, 1'b0);
    drive_cycle(1, 0, 0, 0, BASE + 32'h40, 1, g, rv, d, e);
    drive_cycle(0, 0, 0, 0, 0, 1, g, rv, d, e);
    check("post_reset_read_recv", rv, 1'b1);
    check("post_reset_read_data", d, mm[16]);
    cyc(0, 0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
